branch_resolution_unit: RTL and testbench

- Other end of the branch history table's update interface.
- Records every prediction issued at fetch in an in-order queue. When execute resolves the branch, compares the actual outcome with the prediction.
- Drives the history-table update (enable, write index, taken) and a one-cycle pipeline flush with redirect PC on a direction mispredict.
- Keeps saturating resolved/mispredict statistics counters.

---
 rtl/branch_resolution_unit_pkg.sv | 24 ++
 rtl/branch_resolution_unit_pred_queue.sv | 53 +++++
 rtl/branch_resolution_unit.sv | 129 ++++++++++++
 tb/tb_branch_resolution_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolution_unit_pkg.sv
// Shared types and constants for the branch resolution unit.
//   bru_state_e : resolution FSM state (RUN / FLUSH)
//   PC_STEP     : fall-through distance added to a branch PC
//   bru_entry_t : queue entry layout at the default widths (LOWER=5, PC_W=32);
//                 parameterised instances build the same layout locally
package branch_resolution_unit_pkg;

  localparam int unsigned PC_STEP = 4;

  localparam int unsigned DEF_LOWER = 5;
  localparam int unsigned DEF_PC_W  = 32;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } bru_state_e;

  typedef struct packed {
    logic [DEF_LOWER-1:0] idx;
    logic [DEF_PC_W-1:0]  pc;
    logic                 pred;
  } bru_entry_t;

endpackage

// File: rtl/branch_resolution_unit_pred_queue.sv
// In-order prediction queue: circular FIFO with a synchronous clear.
//   clk, arst_n : clock, asynchronous active-low reset
//   clr         : drop every entry (rd_ptr jumps to wr_ptr); overrides push/pop
//   push, data  : write one entry (caller guarantees not full)
//   pop         : retire the head entry (caller guarantees not empty)
//   head        : oldest entry
//   count       : occupancy, 0..DEPTH
module pred_queue #(
  parameter int unsigned W     = 38,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic [W-1:0]               data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr] <= data;
    end
  end

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/branch_resolution_unit.sv
// Branch resolution unit: tracks predictions issued at fetch, resolves them
// in order against execute's actual direction, drives the history-table
// update, flushes and redirects fetch on a direction mispredict, and keeps
// saturating statistics.
//   clk, arst_n                         : clock, asynchronous active-low reset
//   push_valid/ready, push_idx/pc/pred  : prediction issued at fetch
//   res_valid, res_taken, res_target    : resolution of the oldest branch
//   upd_en, upd_addr, upd_taken         : history-table update (registered)
//   flush, redirect_pc                  : one-cycle squash and restart PC
//   cnt_resolved, cnt_mispred           : saturating statistics
//   err_underflow                       : sticky, resolve with empty queue
module branch_resolution_unit
  import branch_resolution_unit_pkg::*;
#(
  parameter int unsigned LOWER = 5,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [LOWER-1:0] push_idx,
  input  logic [PC_W-1:0]  push_pc,
  input  logic             push_pred,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic [PC_W-1:0]  res_target,
  output logic             upd_en,
  output logic [LOWER-1:0] upd_addr,
  output logic             upd_taken,
  output logic             flush,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] cnt_resolved,
  output logic [CNT_W-1:0] cnt_mispred,
  output logic             err_underflow
);

  localparam int unsigned QC_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [LOWER-1:0] idx;
    logic [PC_W-1:0]  pc;
    logic             pred;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

  bru_state_e       state, state_next;
  entry_t           push_entry, head;
  logic [ENTRY_W-1:0] head_bits;
  logic [QC_W-1:0]  q_count;
  logic             push_acc, res_acc, underflow, mispred;
  logic [PC_W-1:0]  redirect_next;

  assign push_entry = '{idx: push_idx, pc: push_pc, pred: push_pred};
  assign head       = head_bits;
  assign push_acc   = push_valid && push_ready;

  pred_queue #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk    (clk),
    .arst_n (arst_n),
    .clr    (mispred),
    .push   (push_acc),
    .data   (push_entry),
    .pop    (res_acc),
    .head   (head_bits),
    .count  (q_count)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= RUN;
    else         state <= state_next;
  end

  // Everything is gated in FLUSH; the queue was just cleared anyway, and
  // res_valid there must not count as an underflow.
  always_comb begin
    state_next = state;
    push_ready = 1'b0;
    res_acc    = 1'b0;
    underflow  = 1'b0;
    mispred    = 1'b0;
    case (state)
      RUN: begin
        push_ready = (q_count != QC_W'(DEPTH));
        res_acc    = res_valid && (q_count != '0);
        underflow  = res_valid && (q_count == '0);
        mispred    = res_acc && (head.pred != res_taken);
        if (mispred) state_next = FLUSH;
      end
      FLUSH:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  assign redirect_next = res_taken ? res_target : head.pc + PC_W'(PC_STEP);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      upd_en        <= 1'b0;
      upd_addr      <= '0;
      upd_taken     <= 1'b0;
      flush         <= 1'b0;
      redirect_pc   <= '0;
      cnt_resolved  <= '0;
      cnt_mispred   <= '0;
      err_underflow <= 1'b0;
    end else begin
      upd_en <= res_acc;
      flush  <= mispred;
      if (res_acc) begin
        upd_addr  <= head.idx;
        upd_taken <= res_taken;
        if (cnt_resolved != '1) cnt_resolved <= cnt_resolved + CNT_W'(1);
      end
      if (mispred) begin
        redirect_pc <= redirect_next;
        if (cnt_mispred != '1) cnt_mispred <= cnt_mispred + CNT_W'(1);
      end
      if (underflow) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolution_unit.sv
module tb_branch_resolution_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        push_valid, push_pred, res_valid, res_taken;
  logic [4:0]  push_idx;
  logic [31:0] push_pc, res_target;

  logic        push_ready, upd_en, upd_taken, flush, err_underflow;
  logic [4:0]  upd_addr;
  logic [31:0] redirect_pc;
  logic [15:0] cnt_resolved, cnt_mispred;

  logic        b_push_ready, b_upd_en, b_upd_taken, b_flush, b_err_underflow;
  logic [4:0]  b_upd_addr;
  logic [31:0] b_redirect_pc;
  logic [1:0]  b_cnt_resolved, b_cnt_mispred;

  always #5 clk = ~clk;

  branch_resolution_unit #(.LOWER(5), .PC_W(32), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .arst_n(arst_n),
    .push_valid(push_valid), .push_ready(push_ready), .push_idx(push_idx),
    .push_pc(push_pc), .push_pred(push_pred),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .upd_en(upd_en), .upd_addr(upd_addr), .upd_taken(upd_taken),
    .flush(flush), .redirect_pc(redirect_pc),
    .cnt_resolved(cnt_resolved), .cnt_mispred(cnt_mispred),
    .err_underflow(err_underflow)
  );

  branch_resolution_unit #(.LOWER(5), .PC_W(32), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk(clk), .arst_n(arst_n),
    .push_valid(push_valid), .push_ready(b_push_ready), .push_idx(push_idx),
    .push_pc(push_pc), .push_pred(push_pred),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .upd_en(b_upd_en), .upd_addr(b_upd_addr), .upd_taken(b_upd_taken),
    .flush(b_flush), .redirect_pc(b_redirect_pc),
    .cnt_resolved(b_cnt_resolved), .cnt_mispred(b_cnt_mispred),
    .err_underflow(b_err_underflow)
  );

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] pc;
    logic        pred;
  } ment_t;

  typedef struct {
    logic [4:0]  addr;
    logic        taken;
    logic        mis;
    logic [31:0] redir;
  } exp_t;

  ment_t       mq[$];
  exp_t        sb[$];
  int          mres, mmis;
  bit          merr, mflush, saw_flush;
  logic [4:0]  m_addr;
  logic        m_taken;
  logic [31:0] m_redir;
  int          total = 0;
  int          bad = 0;

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic model_reset();
    mq.delete();
    sb.delete();
    mres = 0; mmis = 0; merr = 0; mflush = 0;
    m_addr = '0; m_taken = 1'b0; m_redir = '0;
  endtask

  task automatic idle_inputs();
    push_valid = 0; push_idx = '0; push_pc = '0; push_pred = 0;
    res_valid = 0; res_taken = 0; res_target = '0;
  endtask

  // One clock: drive, advance the model, push expected update into the
  // scoreboard, then pop and compare after the edge.
  task automatic cycle(input bit pv, input logic [4:0] idx, input logic [31:0] pc,
                       input bit pred, input bit rv, input bit rt, input logic [31:0] tgt);
    bit    exp_ready, pacc, racc;
    ment_t h;
    exp_t  e;
    push_valid = pv; push_idx = idx; push_pc = pc; push_pred = pred;
    res_valid = rv; res_taken = rt; res_target = tgt;
    #1;
    exp_ready = (mq.size() < DEPTH) && !mflush;
    total++;
    if (push_ready !== exp_ready) begin
      bad++; $display("FAIL push_ready got=%0b exp=%0b t=%0t", push_ready, exp_ready, $time);
    end
    pacc = pv && exp_ready;
    racc = rv && (mq.size() != 0) && !mflush;
    if (rv && mq.size() == 0 && !mflush) merr = 1;
    mflush = 0;
    if (racc) begin
      h = mq.pop_front();
      e.addr = h.idx; e.taken = rt; e.mis = (h.pred != rt);
      e.redir = rt ? tgt : h.pc + 32'd4;
      sb.push_back(e);
      mres++;
      if (e.mis) begin
        mmis++; mq.delete(); mflush = 1; pacc = 0;
      end
    end
    if (pacc) mq.push_back(ment_t'{idx, pc, pred});
    @(posedge clk); #1;
    idle_inputs();
    if (sb.size() != 0) begin
      e = sb.pop_front();
      m_addr = e.addr; m_taken = e.taken;
      if (e.mis) m_redir = e.redir;
      total++;
      if (upd_en !== 1'b1 || flush !== e.mis) begin
        bad++; $display("FAIL upd_en/flush got=%0b/%0b exp=1/%0b t=%0t", upd_en, flush, e.mis, $time);
      end
    end else begin
      total++;
      if (upd_en !== 1'b0 || flush !== 1'b0) begin
        bad++; $display("FAIL idle_upd got upd_en=%0b flush=%0b exp=0/0 t=%0t", upd_en, flush, $time);
      end
    end
    if (flush === 1'b1) saw_flush = 1;
    total++;
    if (upd_addr !== m_addr || upd_taken !== m_taken) begin
      bad++; $display("FAIL upd_fields got=%0d/%0b exp=%0d/%0b t=%0t", upd_addr, upd_taken, m_addr, m_taken, $time);
    end
    total++;
    if (redirect_pc !== m_redir) begin
      bad++; $display("FAIL redirect_pc got=%h exp=%h t=%0t", redirect_pc, m_redir, $time);
    end
    total++;
    if (cnt_resolved !== 16'(sat(mres, 65535)) || cnt_mispred !== 16'(sat(mmis, 65535)) || err_underflow !== merr) begin
      bad++; $display("FAIL stats got=%0d/%0d/%0b exp=%0d/%0d/%0b t=%0t",
                      cnt_resolved, cnt_mispred, err_underflow, mres, mmis, merr, $time);
    end
    total++;
    if (b_cnt_resolved !== 2'(sat(mres, 3)) || b_cnt_mispred !== 2'(sat(mmis, 3)) || b_err_underflow !== merr) begin
      bad++; $display("FAIL stats_w2 got=%0d/%0d/%0b exp=%0d/%0d/%0b t=%0t",
                      b_cnt_resolved, b_cnt_mispred, b_err_underflow, sat(mres, 3), sat(mmis, 3), merr, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    total++;
    if ({upd_en, upd_addr, upd_taken, flush, redirect_pc, cnt_resolved, cnt_mispred, err_underflow} !== '0 ||
        {b_upd_en, b_upd_addr, b_upd_taken, b_flush, b_redirect_pc, b_cnt_resolved, b_cnt_mispred, b_err_underflow} !== '0 ||
        push_ready !== 1'b1 || b_push_ready !== 1'b1) begin
      bad++; $display("FAIL %s got upd_en=%0b addr=%0d flush=%0b pc=%h res=%0d mis=%0d err=%0b ready=%0b exp=all 0, ready=1",
                      tag, upd_en, upd_addr, flush, redirect_pc, cnt_resolved, cnt_mispred, err_underflow, push_ready);
    end
  endtask

  task automatic do_reset();
    arst_n = 0;
    idle_inputs();
    #3;
    check_all_zero("reset_state");
    @(negedge clk);
    arst_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_correct();
    cycle(1, 5'd3, 32'h40, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 1, 32'h80);
    total++;
    if (upd_en !== 1 || upd_addr !== 5'd3 || upd_taken !== 1 || flush !== 0 || cnt_resolved !== 16'd1 || cnt_mispred !== 16'd0) begin
      bad++; $display("FAIL correct_pred got en=%0b addr=%0d tk=%0b fl=%0b res=%0d mis=%0d exp=1/3/1/0/1/0",
                      upd_en, upd_addr, upd_taken, flush, cnt_resolved, cnt_mispred);
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_mispredict();
    cycle(1, 5'd5, 32'h100, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 32'h999);
    total++;
    if (flush !== 1 || redirect_pc !== 32'h104 || upd_taken !== 0 || cnt_mispred !== 16'd1 || push_ready !== 0) begin
      bad++; $display("FAIL mispredict got fl=%0b pc=%h tk=%0b mis=%0d rdy=%0b exp=1/104/0/1/0",
                      flush, redirect_pc, upd_taken, cnt_mispred, push_ready);
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
    total++;
    if (flush !== 0 || push_ready !== 1) begin
      bad++; $display("FAIL after_flush got fl=%0b rdy=%0b exp=0/1", flush, push_ready);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) cycle(1, 5'(10 + i), 32'h200 + 32'(i * 4), 0, 0, 0, 0);
    total++;
    if (push_ready !== 0) begin
      bad++; $display("FAIL full_ready got=%0b exp=0", push_ready);
    end
    cycle(1, 5'd20, 32'h300, 0, 1, 0, 0);
    total++;
    if (mq.size() != 3 || push_ready !== 1) begin
      bad++; $display("FAIL full_no_bypass got model_count=%0d rdy=%0b exp=3/1", mq.size(), push_ready);
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic test_flush_with_push();
    for (int i = 0; i < 3; i++) cycle(1, 5'(i + 1), 32'h400 + 32'(i * 4), 0, 0, 0, 0);
    cycle(1, 5'd9, 32'h500, 0, 1, 1, 32'h600);
    cycle(0, 0, 0, 0, 1, 0, 0);   // FLUSH cycle: resolve ignored, no error
    total++;
    if (err_underflow !== 0) begin
      bad++; $display("FAIL flush_ignores_res got err=%0b exp=0", err_underflow);
    end
    cycle(0, 0, 0, 0, 1, 1, 0);
    total++;
    if (err_underflow !== 1 || upd_en !== 0) begin
      bad++; $display("FAIL underflow got err=%0b en=%0b exp=1/0", err_underflow, upd_en);
    end
  endtask

  task automatic test_wrap();
    int pushed = 0;
    int cycles = 0;
    do_reset();
    saw_flush = 0;
    while (mres < 2 * DEPTH + 1 && cycles < 60) begin
      bit pv, rv, rt;
      pv = pushed < 2 * DEPTH + 1;
      rv = (mq.size() != 0) && (pushed >= DEPTH);
      rt = (mq.size() != 0) ? mq[0].pred : 1'b0;
      if (pv && mq.size() < DEPTH) pushed++;
      cycle(pv, 5'(pushed + 7), 32'h1000 + 32'(pushed * 16), 1'($urandom_range(0, 1)), rv, rt, 32'h2000);
      cycles++;
    end
    total++;
    if (cnt_resolved !== 16'd9 || saw_flush) begin
      bad++; $display("FAIL wrap got res=%0d flush_seen=%0b exp=9/0", cnt_resolved, saw_flush);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 5; i++) begin
      cycle(1, 5'(i), 32'h3000, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0);
    end
    total++;
    if (b_cnt_mispred !== 2'd3 || cnt_mispred !== 16'd5) begin
      bad++; $display("FAIL saturate got w2=%0d w16=%0d exp=3/5", b_cnt_mispred, cnt_mispred);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1, 5'd1, 32'h50, 1, 0, 0, 0);
    cycle(1, 5'd2, 32'h54, 0, 1, 1, 32'h70);
    #2;
    arst_n = 0;
    #1;
    check_all_zero("reset_mid");
    @(negedge clk);
    arst_n = 1;
    model_reset();
    #1;
    check_all_zero("reset_release");
    cycle(0, 0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    saw_flush = 0;
    test_reset();
    test_correct();
    test_mispredict();
    test_full();
    test_flush_with_push();
    test_wrap();
    test_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
